// File: rtl/counter_share_arb.sv
// Round-robin arbiter sharing one up/down counter among NREQ requesters.
// One operation per cycle; grant, counter and wrap flags all update together from flops.
module counter_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2,
  parameter int SAT   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           up,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic [WIDTH-1:0]          counter,
  output logic                      ovf,
  output logic                      unf
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    OP_NONE,
    OP_INC,
    OP_DEC
  } op_e;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             found;
  op_e              op;
  logic [WIDTH-1:0] cnt_n;
  logic             ovf_n;
  logic             unf_n;
  logic [NREQ-1:0]  gnt_n;

  // Scan starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    op = OP_NONE;
    if (found) begin
      op = up[win] ? OP_INC : OP_DEC;
    end
  end

  always_comb begin
    cnt_n = counter;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    case (op)
      OP_INC: begin
        if (counter == '1) begin
          ovf_n = 1'b1;
          cnt_n = (SAT != 0) ? counter : '0;
        end else begin
          cnt_n = counter + WIDTH'(1);
        end
      end
      OP_DEC: begin
        if (counter == '0) begin
          unf_n = 1'b1;
          cnt_n = (SAT != 0) ? counter : '1;
        end else begin
          cnt_n = counter - WIDTH'(1);
        end
      end
      default: begin
        cnt_n = counter;
      end
    endcase
  end

  always_comb begin
    gnt_n = NREQ'(1) << win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      gnt_id  <= '0;
      counter <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      ptr     <= IDW'(NREQ - 1);
    end else if (op != OP_NONE) begin
      gnt     <= gnt_n;
      gnt_id  <= win;
      ptr     <= win;
      counter <= cnt_n;
      ovf     <= ovf_n;
      unf     <= unf_n;
    end else begin
      gnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end
  end

endmodule

// File: doc/counter_share_arb.md
# counter_share_arb

Round-robin arbiter that shares one up/down counter among NREQ requesters. Each cycle it samples all pending requests, grants exactly one, and applies that requester's increment or decrement to the shared counter register, flagging wrap-around. It sits between independent control agents and the counter datapath, replacing per-agent counters with one shared resource.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 2: counter width in bits
- SAT, 0: 0 = modulo wrap; 1 = saturate at 0 and 2^WIDTH-1
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level
- up  in  NREQ  per-requester direction: 1 = increment, 0 = decrement
- gnt  out  NREQ  registered one-hot grant, one-cycle pulse per serviced operation
- gnt_id  out  $clog2(NREQ)  index of the granted requester; valid when gnt != 0
- counter  out  WIDTH  shared counter value, registered
- ovf  out  1  one-cycle pulse: increment wrapped max -> 0 (SAT=0) or was blocked at max (SAT=1)
- unf  out  1  one-cycle pulse: decrement wrapped 0 -> max (SAT=0) or was blocked at 0 (SAT=1)

## Operation
- Reset (rst=1 at an edge): counter=0, gnt=0, gnt_id=0, ovf=0, unf=0, last-grant pointer=NREQ-1, so req[0] has top priority after reset. Reset overrides any pending request in the same cycle.
- Arbitration at each edge with rst=0: search req starting at index (ptr+1) mod NREQ, ascending with wrap. The first set bit i wins.
- On a win: gnt<=onehot(i), gnt_id<=i, ptr<=i.
  - If up[i]=1: counter<=counter+1. If SAT=1 and the counter is at max, it stays at max.
  - If up[i]=0: counter<=counter-1. If SAT=1 and the counter is at 0, it stays at 0.
- No request: gnt<=0, ovf<=0, unf<=0. Counter and ptr hold. gnt_id holds its last value and is don't-care.
- Arithmetic is WIDTH-bit unsigned. SAT=0 wraps modulo 2^WIDTH.
- ovf/unf pulse only in the cycle whose gnt carries the wrapping or blocked operation. They are never high together.
- Handshake: req is a level. Each gnt[i] pulse services exactly one operation. A requester wanting one operation drops req[i] in the cycle it sees gnt[i]=1. If req[i] is still high at the next edge, that is a new request.
- Fairness: with all NREQ requesting continuously, each is granted exactly once every NREQ cycles. A sole requester is granted every cycle.
- up[] is sampled only for the winner, at the same edge as req.
- No FSM beyond the ptr register. Logical states are IDLE (no req) and GRANT (≥1 req), decided per cycle.

## Timing
- Latency: req/up sampled at edge N. gnt, gnt_id, counter, ovf and unf all update at edge N and are visible during cycle N..N+1. There is zero extra pipeline; the new counter value and the grant appear together.
- Throughput: one counter operation per cycle, maximum.
- rst asserted mid-stream: at that edge every output returns to its reset value and ptr=NREQ-1. The first grant after reset occurs at the first edge with rst=0 and req!=0.
- A req change between edges has no effect. Only values at the edge matter.
- All outputs are driven from flops. There is no combinational path from req/up to any output.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111. Required: gnt=0, counter=0, ovf=unf=0 throughout. First edge after rst=0 gives gnt=4'b0001.
- Round-robin: NREQ=4, req=4'b1111 and up=4'b1111 held 8 cycles. Required: gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000. counter sequence 1,2,3,0,1,2,3,0. ovf pulses on the cycles counter shows 0.
- Skip and wrap of pointer: req=4'b1010 after reset. Required: grants 0010,1000,0010,1000.
- Underflow: sole requester req=4'b0100, up=0, from counter=0. Required (SAT=0): counter 3 with unf=1, then 2, then 1 with unf=0. Required (SAT=1): counter stays 0 with unf=1 every cycle.
- Overflow, SAT=1: sole requester up=1 for 5 cycles from 0. Required: counter 1,2,3,3,3 and ovf=1 on the 4th and 5th cycles.
- Mid-stream reset: all requesting, rst=1 for one cycle at counter=2. Required: next cycle counter=0, gnt=0. Following cycle gnt=4'b0001, counter=1.
